ps2_keycode_rx: RTL and testbench

//  Device-to-host PS/2 receiver: the producer side of the 16-bit keycode bus consumed by movement control.
//  - Samples raw ps2_clk/ps2_data pins and deserialises 11-bit frames.
//  - Checks framing, then shifts each accepted byte into keycode as {previous byte, latest byte}.
//  - This lets downstream logic see break (F0) prefixes.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_clk_filter.sv | 72 +++++++
 rtl/ps2_keycode_rx.sv | 141 ++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver and its consumers.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_rx_state_t;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXTEND = 8'hE0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_D = 8'h23;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
        return ^{data_byte, parity_bit};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Pin conditioning for the PS/2 receiver: synchronisers on both pins, a
// persistence filter on ps2_clk and a single-cycle falling-edge strobe.
module ps2_clk_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data_s
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   filt_q, filt_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   fall_q, fall_d;
    logic                   data_q, data_d;
    logic                   clk_s;

    assign clk_sync_d[0]  = ps2_clk;
    assign data_sync_d[0] = ps2_data;

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign clk_sync_d[gi]  = clk_sync_q[gi-1];
        assign data_sync_d[gi] = data_sync_q[gi-1];
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];

    // The level only flips once FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (clk_s != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = clk_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
        data_d = data_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
            data_q      <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
            data_q      <= data_d;
        end
    end

    assign fall   = fall_q;
    assign data_s = data_q;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host receiver producing a {previous, latest} keycode pair.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not hold.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 65_000_000,
    parameter int TIMEOUT_US  = 200,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        keycode_valid,
    output logic        frame_err
);

    localparam int TIMEOUT_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT_CYC);

    logic fall;
    logic data_s;

    ps2_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .fall     (fall),
        .data_s   (data_s)
    );

    ps2_rx_state_t state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   keycode_q, keycode_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          parity_ok;
    logic          timed_out;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = odd_parity_ok(shift_q, par_q);
`else
    // Parity is still captured so the frame layout is identical; it just never rejects.
    logic unused_parity;
    assign unused_parity = par_q;
    assign parity_ok     = 1'b1;
`endif

    // A fall arriving in the same cycle as the limit keeps the frame alive.
    assign timed_out = (state_q != IDLE) && !fall && (tmo_q == TIMEOUT_LIM);

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        keycode_d = keycode_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        tmo_d     = tmo_q;

        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q != TIMEOUT_LIM) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (timed_out) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d  = DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s && parity_ok) begin
                        keycode_d = {keycode_q[7:0], shift_q};
                        valid_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bitcnt_q  <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            keycode_q <= 16'h0000;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            keycode_q <= keycode_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign keycode       = keycode_q;
    assign keycode_valid = valid_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: table of frames, hand-built corner
// sequences and randomized frames against a frame-level reference model.
module tb_ps2_keycode_rx;
    import ps2_pkg::*;

    localparam int CLK_HZ  = 1_000_000;
    localparam int TMO_US  = 200;
    localparam int NRAND   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] keycode;
    logic        keycode_valid;
    logic        frame_err;

    ps2_keycode_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .TIMEOUT_US  (TMO_US),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .keycode       (keycode),
        .keycode_valid (keycode_valid),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor: counts pulses and flags keycode changes not accompanied by valid.
    int          cyc = 0;
    int          vcnt = 0;
    int          ecnt = 0;
    int          stray = 0;
    int          last_err_cyc = 0;
    int          last_fall_cyc = 0;
    logic [15:0] last_key = 16'h0000;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (keycode_valid === 1'b1) vcnt = vcnt + 1;
        if (frame_err === 1'b1) begin
            ecnt = ecnt + 1;
            last_err_cyc = cyc;
        end
        if (!rst && keycode !== last_key && keycode_valid !== 1'b1) stray = stray + 1;
        last_key = keycode;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // Drive the first nbits of an 11-bit frame, LSB (start bit) first.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int nbits, input int h);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(h);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            tick(h);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic run_frame(input string nm, input logic [7:0] d, input logic p, input logic s,
                             input int h, input logic [15:0] exp_key, input logic exp_v,
                             input logic exp_e);
        int v0, e0, s0;
        v0 = vcnt; e0 = ecnt; s0 = stray;
        send_frame(d, p, s, 11, h);
        ps2_data = 1'b1;
        tick(16);
        $display("frame %s data=%02h par=%0d stop=%0d -> keycode=%04h valid=%0d err=%0d",
                 nm, d, p, s, keycode, vcnt - v0, ecnt - e0);
        chk({nm, "_valid_pulses"}, vcnt - v0, int'(exp_v));
        chk({nm, "_err_pulses"}, ecnt - e0, int'(exp_e));
        chk({nm, "_keycode"}, int'(keycode), int'(exp_key));
        chk({nm, "_key_without_valid"}, stray - s0, 0);
    endtask

    // Reference model: decides a frame's fate from framing rules alone.
    logic [15:0] mkey;

    task automatic model_frame(input logic [7:0] d, input logic p, input logic s,
                               output logic v, output logic e);
        bit par_ok, acc;
        par_ok = ((($countones(d) + int'(p)) % 2) == 1);
`ifdef PS2_PARITY_CHECK_EN
        acc = s && par_ok;
`else
        acc = s;
        if (!par_ok) acc = s;
`endif
        if (acc) mkey = {mkey[7:0], d};
        v = acc;
        e = !acc;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        stop;
        logic [15:0] exp_key;
        logic        exp_v;
        logic        exp_e;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int v0, e0, s0, lat;
        logic [7:0] d;
        logic p, s, ev, ee;
        int h;

        tbl[0] = '{KEY_W,      1'b1, 1'b1, 16'h001D, 1'b1, 1'b0};
        tbl[1] = '{PS2_BREAK,  1'b1, 1'b1, 16'h1DF0, 1'b1, 1'b0};
        tbl[2] = '{KEY_W,      1'b1, 1'b1, 16'hF01D, 1'b1, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
        tbl[3] = '{KEY_D,      1'b1, 1'b1, 16'hF01D, 1'b0, 1'b1};
        tbl[4] = '{KEY_S,      1'b1, 1'b0, 16'hF01D, 1'b0, 1'b1};
        tbl[5] = '{PS2_EXTEND, 1'b0, 1'b1, 16'h1DE0, 1'b1, 1'b0};
`else
        tbl[3] = '{KEY_D,      1'b1, 1'b1, 16'h1D23, 1'b1, 1'b0};
        tbl[4] = '{KEY_S,      1'b1, 1'b0, 16'h1D23, 1'b0, 1'b1};
        tbl[5] = '{PS2_EXTEND, 1'b0, 1'b1, 16'h23E0, 1'b1, 1'b0};
`endif
        tbl[6] = '{8'h00,      1'b1, 1'b1, 16'hE000, 1'b1, 1'b0};
        tbl[7] = '{8'hFF,      1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0};

        // Reset state
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        chk("reset_keycode", int'(keycode), 0);
        chk("reset_valid", int'(keycode_valid), 0);
        chk("reset_err", int'(frame_err), 0);

        for (int i = 0; i < 8; i++) begin
            run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].par, tbl[i].stop, 20,
                      tbl[i].exp_key, tbl[i].exp_v, tbl[i].exp_e);
        end
        mkey = 16'h00FF;

        // Timeout: start + 3 data bits, then the clock stops.
        v0 = vcnt; e0 = ecnt;
        send_frame(KEY_S, 1'b1, 1'b1, 4, 20);
        ps2_data = 1'b1;
        tick(250);
        lat = last_err_cyc - last_fall_cyc;
        $display("timeout frame: err=%0d latency=%0d cycles", ecnt - e0, lat);
        chk("timeout_err_pulses", ecnt - e0, 1);
        chk("timeout_valid_pulses", vcnt - v0, 0);
        chk("timeout_keycode", int'(keycode), int'(mkey));
        chk_range("timeout_latency", lat, 204, 212);
        model_frame(KEY_S, 1'b1, 1'b1, ev, ee);
        run_frame("after_timeout", KEY_S, 1'b1, 1'b1, 20, mkey, ev, ee);

        // Case a: short clock glitch in IDLE with data low.
        v0 = vcnt; e0 = ecnt; s0 = stray;
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        tick(2);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(250);
        $display("glitch: valid=%0d err=%0d keycode=%04h", vcnt - v0, ecnt - e0, keycode);
        chk("glitch_valid_pulses", vcnt - v0, 0);
        chk("glitch_err_pulses", ecnt - e0, 0);
        chk("glitch_keycode", int'(keycode), int'(mkey));
        model_frame(KEY_W, 1'b1, 1'b1, ev, ee);
        run_frame("after_glitch", KEY_W, 1'b1, 1'b1, 20, mkey, ev, ee);

        // Case b: reset while data bit 4 is on the wire.
        e0 = ecnt;
        send_frame(KEY_A, 1'b0, 1'b1, 5, 20);
        ps2_data = KEY_A[4];
        tick(5);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        $display("reset mid-frame: keycode=%04h valid=%0d err=%0d", keycode, keycode_valid, frame_err);
        chk("midreset_keycode", int'(keycode), 0);
        chk("midreset_valid", int'(keycode_valid), 0);
        chk("midreset_err", int'(frame_err), 0);
        ps2_data = 1'b1;
        tick(250);
        chk("midreset_err_pulses", ecnt - e0, 0);
        mkey = 16'h0000;
        model_frame(KEY_A, 1'b0, 1'b1, ev, ee);
        run_frame("after_reset", KEY_A, 1'b0, 1'b1, 20, 16'h001C, ev, ee);
        chk("after_reset_model", int'(mkey), int'(16'h001C));

        // Randomized frames checked against the model.
        for (int i = 0; i < NRAND; i++) begin
            d = 8'($urandom_range(0, 255));
            p = ~(^d);
            if ($urandom_range(0, 99) < 15) p = ~p;
            s = ($urandom_range(0, 99) < 12) ? 1'b0 : 1'b1;
            h = $urandom_range(12, 40);
            model_frame(d, p, s, ev, ee);
            run_frame($sformatf("rnd%0d", i), d, p, s, h, mkey, ev, ee);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
